// File: rtl/lifting53_row_filter.sv
// Le Gall 5/3 integer lifting stage: turns a stream of {even,odd} pixel pairs into {L,H} coefficient
// pairs, with symmetric extension at both ends of every line and a one-pair look-ahead.
module lifting53_row_filter #(
    parameter int WIDTH    = 256,
    parameter int H_OFFSET = 128,
    localparam int PW      = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   i_pair,
    input  logic          i_valid,
    input  logic [PW-1:0] i_pixel_ptr,
    input  logic [PW-1:0] i_row_ptr,
    input  logic          i_last,
    output logic [15:0]   o_coef,
    output logic          o_valid,
    output logic [PW-1:0] o_pixel_ptr,
    output logic [PW-1:0] o_row_ptr
);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    localparam logic signed [11:0] H_OFF = 12'(H_OFFSET);

    function automatic logic signed [11:0] ext(input logic [7:0] x);
        return signed'({4'b0000, x});
    endfunction

    // d = x_odd - floor((x_even + x_next_even) / 2)
    function automatic logic signed [11:0] detail(input logic [7:0] xe, input logic [7:0] xo,
                                                  input logic [7:0] xn);
        return ext(xo) - ((ext(xe) + ext(xn)) >>> 1);
    endfunction

    // s = x_even + floor((d_left + d_right + 2) / 4)
    function automatic logic signed [11:0] smooth(input logic [7:0] xe,
                                                  input logic signed [11:0] dl,
                                                  input logic signed [11:0] dr);
        return ext(xe) + ((dl + dr + 12'sd2) >>> 2);
    endfunction

    function automatic logic [7:0] sat(input logic signed [11:0] v);
        if (v < 12'sd0) begin
            return 8'd0;
        end
        if (v > 12'sd255) begin
            return 8'hFF;
        end
        return v[7:0];
    endfunction

    state_t             state_reg;
    state_t             state_next;

    logic [7:0]         in_even;
    logic [7:0]         in_odd;

    logic [7:0]         held_even_reg;
    logic [7:0]         held_odd_reg;
    logic [PW-1:0]      held_pix_reg;
    logic [PW-1:0]      held_row_reg;
    logic               held_first_reg;
    logic signed [11:0] d_prev_reg;

    logic               pend_valid_reg;
    logic [15:0]        pend_coef_reg;
    logic [PW-1:0]      pend_pix_reg;
    logic [PW-1:0]      pend_row_reg;

    logic               pair_done;
    logic               load_pair;
    logic               last_pair;
    logic signed [11:0] d_held;
    logic signed [11:0] dm1_held;
    logic signed [11:0] d_last;
    logic signed [11:0] dm1_last;
    logic [15:0]        coef_held;
    logic [15:0]        coef_last;

    assign in_even = i_pair[15:8];
    assign in_odd  = i_pair[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (i_valid) begin
            state_next = i_last ? IDLE : HELD;
        end
    end

    always_comb begin
        // A ptr==0 pair while HELD restarts the line: the held partial pair is dropped silently.
        pair_done = i_valid && (state_reg == HELD) && (i_pixel_ptr != '0);
        load_pair = i_valid && !i_last;
        last_pair = i_valid && i_last;

        d_held    = detail(held_even_reg, held_odd_reg, in_even);
        dm1_held  = held_first_reg ? d_held : d_prev_reg;
        coef_held = {sat(smooth(held_even_reg, dm1_held, d_held)), sat((d_held >>> 1) + H_OFF)};

        // Final pair mirrors its own even sample; its left detail is the one just completed, or
        // its own when the line is a single pair.
        d_last    = detail(in_even, in_odd, in_even);
        dm1_last  = pair_done ? d_held : d_last;
        coef_last = {sat(smooth(in_even, dm1_last, d_last)), sat((d_last >>> 1) + H_OFF)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_even_reg  <= '0;
            held_odd_reg   <= '0;
            held_pix_reg   <= '0;
            held_row_reg   <= '0;
            held_first_reg <= 1'b1;
            d_prev_reg     <= '0;
            pend_valid_reg <= 1'b0;
            pend_coef_reg  <= '0;
            pend_pix_reg   <= '0;
            pend_row_reg   <= '0;
        end else begin
            if (load_pair) begin
                held_even_reg  <= in_even;
                held_odd_reg   <= in_odd;
                held_pix_reg   <= i_pixel_ptr;
                held_row_reg   <= i_row_ptr;
                held_first_reg <= !pair_done;
            end
            if (pair_done) begin
                d_prev_reg <= d_held;
            end
            pend_valid_reg <= last_pair;
            if (last_pair) begin
                pend_coef_reg <= coef_last;
                pend_pix_reg  <= i_pixel_ptr;
                pend_row_reg  <= i_row_ptr;
            end
        end
    end

    // The pending slot is only full the cycle after a line end, when no held pair can complete,
    // so the two output sources never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid     <= 1'b0;
            o_coef      <= '0;
            o_pixel_ptr <= '0;
            o_row_ptr   <= '0;
        end else begin
            o_valid <= pend_valid_reg || pair_done;
            if (pend_valid_reg) begin
                o_coef      <= pend_coef_reg;
                o_pixel_ptr <= pend_pix_reg;
                o_row_ptr   <= pend_row_reg;
            end else if (pair_done) begin
                o_coef      <= coef_held;
                o_pixel_ptr <= held_pix_reg;
                o_row_ptr   <= held_row_reg;
            end
        end
    end

endmodule
